branch_predictor: RTL and testbench

Dynamic branch predictor for the single-issue core: a direct-mapped branch history table (BHT) of 2-bit saturating counters plus a direct-mapped branch target buffer (BTB). The fetch stage queries it with the fetch PC and receives a registered taken/target prediction one cycle later. The execute stage trains it with the resolved branch outcome (`exu_is_branch_out`, `exu_branch_taken_out`, `exu_branch_pc_out`, `exu_target_pc_out`). The prediction travels down the pipe as `predicted_taken` and is checked at execute.

---
 rtl/branch_predictor_pkg.sv | 41 ++++
 rtl/branch_predictor_btb.sv | 61 ++++++
 rtl/branch_predictor.sv | 83 ++++++++
 tb/tb_branch_predictor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and sizing for the BHT/BTB branch predictor.
// The XLEN define may be overridden by the core build; 32 is the default.
`ifndef XLEN
`define XLEN 32
`endif

package branch_predictor_pkg;

    localparam int XLEN        = `XLEN;
    localparam int BHT_ENTRIES = 64;
    localparam int BTB_ENTRIES = 16;

    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int BTB_TAG_W = XLEN - BTB_IDX_W - 2;

    localparam logic [1:0] CTR_WEAK_NT = 2'd1;

    typedef struct packed {
        logic            vld;
        logic            taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } bp_upd_t;

    typedef struct packed {
        logic            vld;
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] target;
    } bp_pred_t;

    // Saturating 2-bit counter step: 0 strong-NT .. 3 strong-T.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
        else
            return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with flop storage and write-first read bypass.
module btb
    import branch_predictor_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_target,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_hit,
    output logic [XLEN-1:0] rd_target
);

    logic                 valid   [BTB_ENTRIES];
    logic [BTB_TAG_W-1:0] tags    [BTB_ENTRIES];
    logic [XLEN-1:0]      targets [BTB_ENTRIES];

    logic [BTB_IDX_W-1:0] wr_idx;
    logic [BTB_IDX_W-1:0] rd_idx;
    logic [BTB_TAG_W-1:0] wr_tag;
    logic [BTB_TAG_W-1:0] rd_tag;
    logic                 rd_valid;
    logic [BTB_TAG_W-1:0] rd_entry_tag;
    logic                 unused_pc_lsbs;

    assign wr_idx = wr_pc[BTB_IDX_W+1:2];
    assign rd_idx = rd_pc[BTB_IDX_W+1:2];
    assign wr_tag = wr_pc[XLEN-1:BTB_IDX_W+2];
    assign rd_tag = rd_pc[XLEN-1:BTB_IDX_W+2];
    assign unused_pc_lsbs = ^{wr_pc[1:0], rd_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid[i]   <= 1'b0;
                tags[i]    <= '0;
                targets[i] <= '0;
            end
        end else if (wr_en) begin
            valid[wr_idx]   <= 1'b1;
            tags[wr_idx]    <= wr_tag;
            targets[wr_idx] <= wr_target;
        end
    end

    // Bypass is by index only; the tag compare below still filters aliases.
    always_comb begin
        rd_valid     = valid[rd_idx];
        rd_entry_tag = tags[rd_idx];
        rd_target    = targets[rd_idx];
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_valid     = 1'b1;
            rd_entry_tag = wr_tag;
            rd_target    = wr_target;
        end
    end

    assign rd_hit = rd_valid && (rd_entry_tag == rd_tag);

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit counter BHT plus BTB, registered one-cycle lookup.
module branch_predictor
    import branch_predictor_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_vld,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic            flush,
    input  logic            upd_vld,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    output logic            pred_vld,
    output logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    bp_upd_t  upd;
    bp_pred_t pred_d;
    bp_pred_t pred_q;

    logic [1:0]           bht [BHT_ENTRIES];
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [BHT_IDX_W-1:0] lkp_idx;
    logic [1:0]           lkp_ctr;
    logic                 btb_hit;
    logic [XLEN-1:0]      btb_target;
    logic                 lkp_live;

    assign upd     = '{vld: upd_vld, taken: upd_taken, pc: upd_pc, target: upd_target};
    assign upd_idx = upd.pc[BHT_IDX_W+1:2];
    assign lkp_idx = fetch_pc[BHT_IDX_W+1:2];

    btb u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (upd.vld && upd.taken),
        .wr_pc     (upd.pc),
        .wr_target (upd.target),
        .rd_pc     (fetch_pc),
        .rd_hit    (btb_hit),
        .rd_target (btb_target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= CTR_WEAK_NT;
        end else if (upd.vld) begin
            bht[upd_idx] <= ctr_next(bht[upd_idx], upd.taken);
        end
    end

    // A same-cycle update to the looked-up counter is seen by the lookup.
    always_comb begin
        lkp_ctr = bht[lkp_idx];
        if (upd.vld && (upd_idx == lkp_idx))
            lkp_ctr = ctr_next(bht[upd_idx], upd.taken);
    end

    always_comb begin
        lkp_live      = fetch_vld && !flush;
        pred_d.vld    = lkp_live;
        pred_d.pc     = lkp_live ? fetch_pc : '0;
        pred_d.taken  = lkp_live && btb_hit && lkp_ctr[1];
        pred_d.target = pred_d.taken ? btb_target : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pred_q <= '0;
        else
            pred_q <= pred_d;
    end

    assign pred_vld    = pred_q.vld;
    assign pred_pc     = pred_q.pc;
    assign pred_taken  = pred_q.taken;
    assign pred_target = pred_q.target;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a table-level reference model.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_vld = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        flush = 1'b0;
    logic        upd_vld = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        pred_vld;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    int errors = 0;
    int checks = 0;

    // Reference model: plain arrays indexed by word address modulo table size.
    int          m_cnt   [64];
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    logic        exp_vld;
    logic        exp_taken;
    logic [31:0] exp_pc;
    logic [31:0] exp_target;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_vld   (fetch_vld),
        .fetch_pc    (fetch_pc),
        .flush       (flush),
        .upd_vld     (upd_vld),
        .upd_taken   (upd_taken),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .pred_vld    (pred_vld),
        .pred_pc     (pred_pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 64; i++) m_cnt[i] = 1;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
        end
        exp_vld = 1'b0; exp_taken = 1'b0; exp_pc = '0; exp_target = '0;
    endtask

    task automatic checkOutput();
        check("pred_vld", {31'd0, pred_vld}, {31'd0, exp_vld});
        check("pred_taken", {31'd0, pred_taken}, {31'd0, exp_taken});
        check("pred_target", pred_target, exp_target);
        if (exp_vld) check("pred_pc", pred_pc, exp_pc);
    endtask

    // One cycle: drive at negedge, advance the model (update before lookup), compare after edge.
    task automatic applyStimulus(input logic fv, input logic [31:0] fpc, input logic fl,
                                 input logic uv, input logic ut,
                                 input logic [31:0] upc, input logic [31:0] utgt);
        int bi, ti;
        bit hit;
        @(negedge clk);
        fetch_vld = fv; fetch_pc = fpc; flush = fl;
        upd_vld = uv; upd_taken = ut; upd_pc = upc; upd_target = utgt;
        if (uv) begin
            bi = int'((upc >> 2) % 64);
            if (ut) begin
                if (m_cnt[bi] < 3) m_cnt[bi]++;
                ti = int'((upc >> 2) % 16);
                m_valid[ti] = 1'b1;
                m_tag[ti]   = upc >> 6;
                m_tgt[ti]   = utgt;
            end else if (m_cnt[bi] > 0) begin
                m_cnt[bi]--;
            end
        end
        ti  = int'((fpc >> 2) % 16);
        bi  = int'((fpc >> 2) % 64);
        hit = m_valid[ti] && (m_tag[ti] == (fpc >> 6));
        exp_vld    = fv && !fl;
        exp_taken  = exp_vld && hit && (m_cnt[bi] >= 2);
        exp_pc     = exp_vld ? fpc : 32'h0;
        exp_target = exp_taken ? m_tgt[ti] : 32'h0;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic lookup(input logic [31:0] pc);
        applyStimulus(1'b1, pc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic train(input logic taken, input logic [31:0] pc, input logic [31:0] tgt);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, taken, pc, tgt);
    endtask

    initial begin
        modelReset();
        #2;
        check("reset_vld", {31'd0, pred_vld}, 32'd0);
        check("reset_target", pred_target, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        lookup(32'h100);
        check("cold_vld", {31'd0, pred_vld}, 32'd1);
        check("cold_taken", {31'd0, pred_taken}, 32'd0);

        train(1'b1, 32'h100, 32'h200);
        lookup(32'h100);
        check("first_taken", {31'd0, pred_taken}, 32'd1);
        check("first_target", pred_target, 32'h200);

        for (int i = 0; i < 3; i++) train(1'b1, 32'h100, 32'h200);
        train(1'b0, 32'h100, 32'h0);
        lookup(32'h100);
        check("nt1_taken", {31'd0, pred_taken}, 32'd1);
        train(1'b0, 32'h100, 32'h0);
        lookup(32'h100);
        check("nt2_taken", {31'd0, pred_taken}, 32'd0);
        train(1'b0, 32'h100, 32'h0);
        lookup(32'h100);
        train(1'b0, 32'h100, 32'h0);
        lookup(32'h100);
        check("sat0_taken", {31'd0, pred_taken}, 32'd0);
        train(1'b1, 32'h100, 32'h204);
        train(1'b1, 32'h100, 32'h200);
        lookup(32'h102);
        check("retrain_target", pred_target, 32'h200);

        lookup(32'h140);
        check("alias_taken", {31'd0, pred_taken}, 32'd0);
        applyStimulus(1'b1, 32'h140, 1'b0, 1'b1, 1'b1, 32'h100, 32'h200);
        train(1'b1, 32'h1140, 32'h900);
        lookup(32'h140);
        check("alias_tag_miss", {31'd0, pred_taken}, 32'd0);
        lookup(32'h1140);
        lookup(32'h100);

        applyStimulus(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h300, 32'h400);
        check("bypass_taken", {31'd0, pred_taken}, 32'd1);
        check("bypass_target", pred_target, 32'h400);

        applyStimulus(1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 32'h500, 32'h600);
        check("flush_vld", {31'd0, pred_vld}, 32'd0);
        lookup(32'h500);
        check("flush_upd_target", pred_target, 32'h600);
        applyStimulus(1'b0, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        train(1'b1, 32'h100, 32'h200);
        train(1'b1, 32'h100, 32'h200);
        lookup(32'h100);
        check("pre_reset_taken", {31'd0, pred_taken}, 32'd1);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        check("midrst_vld", {31'd0, pred_vld}, 32'd0);
        check("midrst_taken", {31'd0, pred_taken}, 32'd0);
        check("midrst_pc", pred_pc, 32'h0);
        check("midrst_target", pred_target, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        lookup(32'h100);
        check("post_reset_taken", {31'd0, pred_taken}, 32'd0);
        lookup(32'h300);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
